// File: rtl/imem_load_if.sv
// Loader bundle: start/length request, byte stream with valid/ready, CPU fetch address,
// and the shared instruction-memory port with hold/done/err status back to the requester.
interface imem_load_if #(
  parameter int ADDR_W = 6
);
  logic              load_start;
  logic [ADDR_W-1:0] load_base;
  logic [ADDR_W:0]   load_len;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;

  modport master (
    output load_start, load_base, load_len, byte_in, byte_valid, fetch_addr,
    input  byte_ready, mem_addr, mem_we, mem_wdata, cpu_hold, done, err
  );

  modport slave (
    input  load_start, load_base, load_len, byte_in, byte_valid, fetch_addr,
    output byte_ready, mem_addr, mem_we, mem_wdata, cpu_hold, done, err
  );
endinterface

// File: rtl/imem_load_ctrl.sv
// Packs a little-endian byte stream into 32-bit words written to a shared instruction memory;
// 5 cycles per word plus start/done (5*len+2 inclusive); byte_ready only in RECV, source holds bytes.
module imem_load_ctrl #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input logic        clk,
  input logic        rst_n,
  imem_load_if.slave bus
);
  localparam int LEN_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        byte_cnt;
  logic [LEN_W-1:0]  word_cnt;
  logic [LEN_W-1:0]  len_q;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       word_q;
  logic              hold_q;
  logic              err_q;
  logic              len_ok;
  logic              start_ok;
  logic              start_bad;
  logic              byte_acc;
  logic              last_word;

  assign len_ok    = (bus.load_len != '0) && (bus.load_len <= LEN_W'(DEPTH));
  assign start_ok  = (state == IDLE) && bus.load_start && len_ok;
  assign start_bad = (state == IDLE) && bus.load_start && !len_ok;
  assign byte_acc  = (state == RECV) && bus.byte_valid;
  assign last_word = (word_cnt + LEN_W'(1)) == len_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = RECV;
      RECV:    if (byte_acc && (byte_cnt == 2'd3)) state_nxt = WRITE;
      WRITE:   state_nxt = last_word ? DONE : RECV;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      byte_cnt <= '0;
      word_cnt <= '0;
      len_q    <= '0;
      wr_addr  <= '0;
      word_q   <= '0;
      hold_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      // Registered hold follows the next state so it drops in the first IDLE cycle.
      hold_q <= (state_nxt != IDLE);
      err_q  <= start_bad;
      if (start_ok) begin
        len_q    <= bus.load_len;
        wr_addr  <= bus.load_base;
        byte_cnt <= '0;
        word_cnt <= '0;
      end
      if (byte_acc) begin
        word_q[{byte_cnt, 3'b000} +: 8] <= bus.byte_in;
        byte_cnt                        <= byte_cnt + 2'd1;
      end
      if (state == WRITE) begin
        word_cnt <= word_cnt + LEN_W'(1);
        wr_addr  <= (wr_addr == ADDR_W'(DEPTH - 1)) ? '0 : wr_addr + ADDR_W'(1);
      end
    end
  end

  assign bus.byte_ready = (state == RECV);
  assign bus.mem_we     = (state == WRITE);
  assign bus.mem_wdata  = word_q;
  assign bus.mem_addr   = (state == IDLE) ? bus.fetch_addr : wr_addr;
  assign bus.cpu_hold   = hold_q;
  assign bus.done       = (state == DONE);
  assign bus.err        = err_q;
endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed and randomized loads checked against a word-level model of the expected memory writes.
module tb_imem_load_ctrl;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  logic [7:0]  src[$];
  logic [7:0]  acc_q[$];
  int          wa_q[$];
  logic [31:0] wd_q[$];
  logic        acc_flag  = 1'b0;
  logic        done_seen = 1'b0;
  int          done_cyc  = 0;
  int          start_cyc = 0;
  int          lat;

  imem_load_if #(.ADDR_W(ADDR_W)) bus ();

  imem_load_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor on the falling edge: records accepted bytes, memory writes and the done pulse.
  always @(negedge clk) begin
    acc_flag = bus.byte_valid && bus.byte_ready;
    if (acc_flag) acc_q.push_back(bus.byte_in);
    if (bus.mem_we) begin
      check("write_after_4_bytes", acc_q.size(), 4 * (wa_q.size() + 1));
      wa_q.push_back(int'(bus.mem_addr));
      wd_q.push_back(bus.mem_wdata);
    end
    if (bus.done) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
    end
  end

  task automatic fill_src(input int n);
    src.delete();
    for (int i = 0; i < n; i++) src.push_back(8'($urandom));
  endtask

  // mode 0: valid always high, 1: valid toggles each cycle, 2: random valid.
  task automatic run_load(input int base, input int len, input int mode, input int abort_bytes,
                          output int latency);
    int idx;
    int guard;
    wa_q.delete();
    wd_q.delete();
    acc_q.delete();
    done_seen = 1'b0;
    latency   = -1;
    @(posedge clk); #1;
    bus.load_start = 1'b1;
    bus.load_base  = ADDR_W'(base);
    bus.load_len   = (ADDR_W + 1)'(len);
    bus.byte_valid = 1'b0;
    start_cyc      = cyc;
    idx   = 0;
    guard = 0;
    forever begin
      @(posedge clk); #1;
      if (done_seen) begin
        bus.load_start = 1'b0;
        bus.byte_valid = 1'b0;
        bus.fetch_addr = ADDR_W'($urandom);
        #1;
        check("hold_low_after_done", bus.cpu_hold, 0);
        check("idle_fetch_addr", bus.mem_addr, bus.fetch_addr);
        check("idle_not_ready", bus.byte_ready, 0);
        latency = done_cyc - start_cyc + 1;
        break;
      end
      if (acc_flag) idx++;
      if (abort_bytes > 0 && acc_q.size() >= abort_bytes) begin
        bus.load_start = 1'b0;
        bus.byte_valid = 1'b0;
        return;
      end
      // Requests while busy must be ignored without err.
      bus.load_start = 1'($urandom_range(0, 1));
      bus.load_len   = (ADDR_W + 1)'($urandom);
      bus.load_base  = ADDR_W'($urandom);
      bus.fetch_addr = ADDR_W'($urandom);
      bus.byte_in    = (idx < src.size()) ? src[idx] : 8'($urandom);
      case (mode)
        0:       bus.byte_valid = (idx < src.size());
        1:       bus.byte_valid = (idx < src.size()) && (guard % 2 == 0);
        default: bus.byte_valid = (idx < src.size()) && ($urandom_range(0, 1) == 1);
      endcase
      #1;
      check("hold_during_load", bus.cpu_hold, 1);
      check("loader_addr", bus.mem_addr, (base + wa_q.size()) % DEPTH);
      check("no_err_when_busy", bus.err, 0);
      guard++;
      if (guard > 4000) begin
        n_cmp++;
        n_bad++;
        $error("FAIL load_timeout: observed no done after %0d cycles, expected done", guard);
        bus.load_start = 1'b0;
        bus.byte_valid = 1'b0;
        return;
      end
    end
    check("write_count", wa_q.size(), len);
    for (int w = 0; w < len && w < wa_q.size(); w++) begin
      check("write_addr", wa_q[w], (base + w) % DEPTH);
      check("write_data", wd_q[w], {src[4*w+3], src[4*w+2], src[4*w+1], src[4*w]});
    end
    check("bytes_accepted", acc_q.size(), 4 * len);
    for (int i = 0; i < acc_q.size() && i < src.size(); i++)
      check("byte_order", acc_q[i], src[i]);
    if (mode == 0) check("latency", latency, 5 * len + 2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.load_start = 1'b0;
    bus.load_base  = '0;
    bus.load_len   = '0;
    bus.byte_in    = '0;
    bus.byte_valid = 1'b0;
    bus.fetch_addr = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_byte_ready", bus.byte_ready, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_cpu_hold", bus.cpu_hold, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    #2 rst_n = 1'b1;

    @(posedge clk); #1;
    bus.fetch_addr = 6'd5;
    #1;
    check("fetch_passthrough", bus.mem_addr, 5);

    // Known two-instruction program at base 0.
    src = {8'h83, 8'h21, 8'h00, 8'h00, 8'h03, 8'h22, 8'h40, 8'h00};
    run_load(0, 2, 0, 0, lat);
    check("prog_word0", wd_q.size() > 0 ? wd_q[0] : 32'hx, 32'h00002183);
    check("prog_word1", wd_q.size() > 1 ? wd_q[1] : 32'hx, 32'h00402203);
    check("prog_done_cycle", lat, 12);

    // Address wrap at the top of memory.
    fill_src(12);
    run_load(62, 3, 0, 0, lat);

    // Rejected lengths: zero and one beyond depth.
    wa_q.delete();
    for (int t = 0; t < 2; t++) begin
      @(posedge clk); #1;
      bus.load_start = 1'b1;
      bus.load_len   = (t == 0) ? 7'd0 : 7'd65;
      bus.load_base  = 6'd3;
      @(posedge clk); #1;
      bus.load_start = 1'b0;
      check("err_pulse", bus.err, 1);
      check("err_no_hold", bus.cpu_hold, 0);
      check("err_not_ready", bus.byte_ready, 0);
      @(posedge clk); #1;
      check("err_one_cycle", bus.err, 0);
    end
    repeat (3) @(posedge clk);
    #1;
    bus.fetch_addr = 6'd17;
    #1;
    check("err_stays_idle", bus.mem_addr, 17);
    check("err_no_writes", wa_q.size(), 0);

    // Valid toggling every cycle.
    fill_src(12);
    run_load($urandom_range(0, DEPTH - 1), 3, 1, 0, lat);

    // Reset after two bytes of the second word.
    fill_src(8);
    run_load(10, 2, 0, 6, lat);
    #1 rst_n = 1'b0;
    #1;
    check("arst_byte_ready", bus.byte_ready, 0);
    check("arst_mem_we", bus.mem_we, 0);
    check("arst_mem_wdata", bus.mem_wdata, 0);
    check("arst_cpu_hold", bus.cpu_hold, 0);
    check("arst_done", bus.done, 0);
    check("arst_err", bus.err, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("arst_no_extra_write", wa_q.size(), 1);
    fill_src(8);
    run_load(20, 2, 0, 0, lat);

    // Randomized loads, then the length boundaries.
    for (int t = 0; t < 4; t++) begin
      int b;
      int l;
      b = $urandom_range(0, DEPTH - 1);
      l = $urandom_range(1, 6);
      fill_src(4 * l);
      run_load(b, l, 2, 0, lat);
    end
    fill_src(4);
    run_load($urandom_range(0, DEPTH - 1), 1, 0, 0, lat);
    fill_src(4 * DEPTH);
    run_load($urandom_range(0, DEPTH - 1), DEPTH, 0, 0, lat);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/imem_load_ctrl.md
IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 6, the instruction-memory word-address width.
REQ-002 The module SHALL have parameter DEPTH, default 64, the instruction-memory depth in words.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port load_start, input, 1 bit: request to begin a program load; sampled only in IDLE.
REQ-006 The module SHALL have port load_base, input, ADDR_W bits: first word address of the load; captured with load_start.
REQ-007 The module SHALL have port load_len, input, ADDR_W+1 bits: number of words to load; captured with load_start.
REQ-008 The module SHALL have port byte_in, input, 8 bits: program byte stream, little-endian within each word.
REQ-009 The module SHALL have port byte_valid, input, 1 bit: byte_in is valid.
REQ-010 The module SHALL have port byte_ready, output, 1 bit: the controller accepts byte_in this cycle.
REQ-011 The module SHALL have port fetch_addr, input, ADDR_W bits: CPU fetch word address (PC[7:2]).
REQ-012 The module SHALL have port mem_addr, output, ADDR_W bits: the single address to the shared instruction memory.
REQ-013 The module SHALL have port mem_we, output, 1 bit: memory write enable.
REQ-014 The module SHALL have port mem_wdata, output, 32 bits: memory write data.
REQ-015 The module SHALL have port cpu_hold, output, 1 bit: stalls CPU fetch while memory is owned by the loader.
REQ-016 The module SHALL have port done, output, 1 bit: one-cycle pulse when a load completes.
REQ-017 The module SHALL have port err, output, 1 bit: one-cycle pulse when load_start is rejected.

Function
REQ-018 The FSM SHALL have states IDLE, RECV, WRITE and DONE.
REQ-019 In IDLE, load_start=1 with 1<=load_len<=DEPTH SHALL capture load_base/load_len, clear the byte and word counters, and move the FSM to RECV.
REQ-020 In IDLE, load_start=1 with load_len=0 or load_len>DEPTH SHALL pulse err for one cycle, with no state change.
REQ-021 load_start outside IDLE SHALL be ignored, with no err.
REQ-022 byte_ready SHALL be 1 only in RECV; a byte SHALL be accepted only when byte_valid&&byte_ready.
REQ-023 Accepted byte k (k=0..3) SHALL be placed in word bits [8k+7:8k]; the byte counter SHALL wrap 3->0.
REQ-024 Acceptance of byte 3 SHALL move the FSM to WRITE the next cycle; byte_ready SHALL be 0 in WRITE.
REQ-025 In WRITE, mem_we SHALL be 1 for exactly one cycle, with mem_wdata = assembled word and mem_addr = (load_base + word_count) mod DEPTH (wrap 63->0).
REQ-026 After WRITE, the word counter SHALL increment; the FSM SHALL go to DONE when word_count equals load_len, otherwise to RECV.
REQ-027 In DONE, done SHALL pulse for one cycle and the FSM SHALL return to IDLE the next cycle.
REQ-028 mem_addr SHALL equal fetch_addr in IDLE, and the loader write address in RECV/WRITE/DONE.
REQ-029 mem_we SHALL be 0 in every state other than WRITE.
REQ-030 cpu_hold SHALL be registered: 1 from the cycle after load_start is accepted through DONE, and 0 in the first IDLE cycle after DONE.
REQ-031 byte_valid while byte_ready=0 SHALL NOT be consumed; the source holds the byte.
REQ-032 Load latency SHALL be 5*load_len + 2 cycles minimum from load_start to done, with byte_valid held continuously high.

Reset
REQ-033 rst_n=0 SHALL immediately force state IDLE, byte_ready=0, mem_we=0, mem_wdata=0, cpu_hold=0, done=0, err=0, and clear all counters, independent of clk.
REQ-034 Reset during a load SHALL discard any partial word, and no write SHALL occur after reset is asserted.

Verification
REQ-035 Test: base=0, len=2, bytes 83,21,00,00,03,22,40,00 -> writes 0x00002183@0 and 0x00402203@1, done at cycle 12, cpu_hold low the cycle after.
REQ-036 Test: base=62, len=3 -> writes at addresses 62, 63, 0 (wrap).
REQ-037 Test: load_len=0, then load_len=65 -> err pulses twice; no state change, mem_we stays 0.
REQ-038 Test: byte_valid toggled 1/0 every cycle -> correct words, each byte accepted exactly once, no write until 4 bytes are accepted.
REQ-039 Test: rst_n low after 2 bytes of word 1 -> outputs take reset values asynchronously; no write; a subsequent load succeeds.
REQ-040 Test: fetch_addr=5 in IDLE -> mem_addr=5; during a load, mem_addr is unaffected by fetch_addr and cpu_hold=1.
